// File: rtl/flags_pkg.sv
// Shared constants and FSM state type for the flags-register load controller.
package flags_pkg;

  localparam int unsigned FLAGS_W = 6;
  localparam int unsigned IdxW    = 3;

  // Bit positions of the individual flags inside reg_flags.
  localparam int unsigned FlagC = 0;
  localparam int unsigned FlagZ = 1;
  localparam int unsigned FlagN = 2;
  localparam int unsigned FlagV = 3;
  localparam int unsigned FlagH = 4;
  localparam int unsigned FlagP = 5;

  typedef enum logic [2:0] {
    StBoot,
    StClear,
    StIdle,
    StLoad,
    StAck
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N_REQ.
module rr_pick
  import flags_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  output logic             valid,
  output logic [IdxW-1:0]  idx
);

  int unsigned pos;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = (32'(ptr) + k) % N_REQ;
      if (!valid && req[IdxW'(pos)]) begin
        valid = 1'b1;
        idx   = IdxW'(pos);
      end
    end
  end

endmodule

// File: rtl/flags_ctrl.sv
// Owns the flags-register load port: clears it after reset, then serves masked partial
// updates from several producers in round-robin order with a per-requester acknowledge.
module flags_ctrl
  import flags_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned W     = FLAGS_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] data,
  input  logic [N_REQ*W-1:0] mask,
  output logic [N_REQ-1:0]   ack,
  output logic [W-1:0]       reg_inp,
  output logic               reg_control,
  input  logic [W-1:0]       reg_out,
  output logic [2:0]         grant_id,
  output logic               flags_pending
);

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [W-1:0]    data_q, data_d;
  logic [W-1:0]    mask_q, mask_d;
  logic            pick_valid;
  logic [IdxW-1:0] pick_idx;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    mask_d   = mask_q;
    unique case (state_q)
      StBoot:  state_d = StClear;
      StClear: state_d = StIdle;
      StIdle: begin
        if (pick_valid) begin
          state_d = StLoad;
          grant_d = pick_idx;
          data_d  = data[32'(pick_idx)*W +: W];
          mask_d  = mask[32'(pick_idx)*W +: W];
        end
      end
      StLoad:  state_d = StAck;
      StAck: begin
        state_d  = StIdle;
        rr_ptr_d = (grant_q == IdxW'(N_REQ-1)) ? '0 : grant_q + IdxW'(1);
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StBoot;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
    end
  end

  // Moore outputs: the register reads back its own value, so LOAD merges against reg_out.
  always_comb begin
    reg_control = 1'b0;
    reg_inp     = '0;
    ack         = '0;
    case (state_q)
      StClear: reg_control = 1'b1;
      StLoad: begin
        reg_control = 1'b1;
        reg_inp     = (reg_out & ~mask_q) | (data_q & mask_q);
      end
      StAck:   ack = N_REQ'(1) << grant_q;
      default: ;
    endcase
  end

  assign grant_id      = grant_q;
  assign flags_pending = (state_q != StIdle) | (|req);

endmodule

// File: tb/tb_flags_ctrl.sv
// Randomised bench for flags_ctrl with a behavioural flags register and a transaction-level
// round-robin / masked-merge reference model.
module tb_flags_ctrl;
  import flags_pkg::*;

  localparam int unsigned N = 3;
  localparam int unsigned W = FLAGS_W;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N*W-1:0] data  = '0;
  logic [N*W-1:0] mask  = '0;
  logic [N-1:0]   ack;
  logic [W-1:0]   reg_inp;
  logic           reg_control;
  logic [W-1:0]   reg_out;
  logic [2:0]     grant_id;
  logic           flags_pending;
  logic [W-1:0]   flags_reg;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [W-1:0] m_flags;
  int           m_ptr;
  logic [W-1:0] m_data[N];
  logic [W-1:0] m_mask[N];

  flags_ctrl #(
    .N_REQ (N),
    .W     (W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .data          (data),
    .mask          (mask),
    .ack           (ack),
    .reg_inp       (reg_inp),
    .reg_control   (reg_control),
    .reg_out       (reg_out),
    .grant_id      (grant_id),
    .flags_pending (flags_pending)
  );

  always #5 clk = ~clk;

  // Flags register without reset, loaded when control is high.
  always @(posedge clk) if (reg_control) flags_reg <= reg_inp;
  assign reg_out = flags_reg;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic raise(input int idx, input logic [W-1:0] d, input logic [W-1:0] m);
    req[idx]         = 1'b1;
    data[idx*W +: W] = d;
    mask[idx*W +: W] = m;
    m_data[idx]      = d;
    m_mask[idx]      = m;
  endtask

  function automatic int next_winner();
    for (int k = 0; k < N; k++) begin
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Waits (bounded) for the next ack and checks who got it, when, and the merged flags.
  task automatic expect_grant(input int exp_lat, input bit keep);
    int           w;
    int           lat;
    bit           seen;
    logic [W-1:0] exp_flags;
    w    = next_winner();
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 8) begin
      @(negedge clk);
      lat++;
      if (ack != '0) seen = 1'b1;
      else check_eq("pending_wait", 32'(flags_pending), 32'd1);
    end
    check_eq("ack_latency", 32'(lat), 32'(exp_lat));
    check_eq("ack_onehot", 32'(ack), 32'(1 << w));
    check_eq("grant_id", 32'(grant_id), 32'(w));
    exp_flags = (m_flags & ~m_mask[w]) | (m_data[w] & m_mask[w]);
    check_eq("flags", 32'(reg_out), 32'(exp_flags));
    check_eq("pending_ack", 32'(flags_pending), 32'd1);
    m_flags = exp_flags;
    m_ptr   = (w + 1) % N;
    if (!keep) req[w] = 1'b0;
  endtask

  task automatic check_idle();
    @(negedge clk);
    check_eq("idle_ack", 32'(ack), 32'd0);
    check_eq("idle_ctl", 32'(reg_control), 32'd0);
    check_eq("idle_pending", 32'(flags_pending), 32'd0);
  endtask

  initial begin
    int n_served;
    m_flags = '0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) begin
      m_data[i] = '0;
      m_mask[i] = '0;
    end

    // Reset values and the CLEAR cycle.
    repeat (2) @(negedge clk);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_ctl", 32'(reg_control), 32'd0);
    check_eq("rst_inp", 32'(reg_inp), 32'd0);
    check_eq("rst_grant", 32'(grant_id), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("clear_ctl", 32'(reg_control), 32'd1);
    check_eq("clear_inp", 32'(reg_inp), 32'd0);
    @(negedge clk);
    check_eq("clear_flags", 32'(reg_out), 32'd0);
    check_eq("boot_ack", 32'(ack), 32'd0);
    check_eq("boot_pending", 32'(flags_pending), 32'd0);

    // Single full-mask write from req0.
    raise(0, 6'b101101, 6'b111111);
    expect_grant(2, 1'b0);
    check_idle();

    // req0 and req1 together: pointer sits at 1, so req1 goes first.
    raise(0, 6'b111111, 6'b111111);
    raise(1, 6'b111111, 6'b111111);
    expect_grant(2, 1'b0);
    expect_grant(3, 1'b0);
    check_idle();

    // Masked merge: 111111 with bits 2:1 cleared.
    raise(1, 6'b000000, 6'b000110);
    expect_grant(2, 1'b0);
    check_eq("merge_value", 32'(reg_out), 32'h39);
    check_idle();

    // Set 010101 from req2 (pointer returns to 0), then an all-zero-mask update.
    raise(2, 6'b010101, 6'b111111);
    expect_grant(2, 1'b0);
    check_idle();
    raise(2, 6'b101010, 6'b000000);
    #1;
    check_eq("zmask_pending_req", 32'(flags_pending), 32'd1);
    expect_grant(2, 1'b0);
    check_eq("zmask_value", 32'(reg_out), 32'h15);
    check_idle();

    // All three held continuously: order 0, 1, 2, 0.
    raise(0, 6'(($urandom)), 6'(($urandom)));
    raise(1, 6'(($urandom)), 6'(($urandom)));
    raise(2, 6'(($urandom)), 6'(($urandom)));
    expect_grant(2, 1'b1);
    expect_grant(3, 1'b1);
    expect_grant(3, 1'b1);
    expect_grant(3, 1'b1);
    req = '0;
    check_idle();

    // Reset during LOAD aborts the transfer; the held request is served after CLEAR.
    raise(1, 6'b110011, 6'b111111);
    @(negedge clk);
    check_eq("load_ctl", 32'(reg_control), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_ack", 32'(ack), 32'd0);
    check_eq("abort_ctl", 32'(reg_control), 32'd0);
    check_eq("abort_inp", 32'(reg_inp), 32'd0);
    check_eq("abort_grant", 32'(grant_id), 32'd0);
    @(negedge clk);
    check_eq("abort_ack_hold", 32'(ack), 32'd0);
    rst_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    check_eq("reclear_ctl", 32'(reg_control), 32'd1);
    check_eq("reclear_inp", 32'(reg_inp), 32'd0);
    @(negedge clk);
    check_eq("reclear_flags", 32'(reg_out), 32'd0);
    m_flags = '0;
    expect_grant(2, 1'b0);
    check_idle();

    // Random request sets with random data and masks.
    for (int it = 0; it < 40; it++) begin
      logic [N-1:0] set;
      set = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        if (set[i]) raise(i, 6'($urandom), 6'($urandom));
      end
      n_served = 0;
      while (req != '0 && n_served < N) begin
        expect_grant((n_served == 0) ? 2 : 3, 1'b0);
        n_served++;
      end
      check_idle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
